regfile_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 36 +++
 rtl/regfile_mp_if.sv | 31 +++
 rtl/regfile_rdport.sv | 54 +++++
 rtl/regfile_mp.sv | 89 ++++++++
 tb/tb_regfile_mp.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types, defaults and the write-port arbitration helper for regfile_mp.
// The helper is shared by the write path and by the RF_BYPASS_EN forwarding path.
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int MAX_NWR   = 2;
   localparam int WP_W      = 1;

   typedef logic [$clog2(NREGS_DEF)-1:0] reg_idx_t;
   typedef logic [MAX_NWR-1:0]           wr_hit_t;

   typedef struct packed {
      logic            hit;
      logic [WP_W-1:0] port;
   } wr_win_t;

   function automatic int aw_of(input int nregs);
      return $clog2(nregs);
   endfunction

   // Callers pass one hit bit per write port for a given address.
   // The scan runs upward, so the highest-indexed hitting port wins.
   function automatic wr_win_t win_port(input wr_hit_t hits);
      wr_win_t w;
      w = '0;
      for (int j = 0; j < MAX_NWR; j++) begin
         if (hits[j]) begin
            w.hit  = 1'b1;
            w.port = WP_W'(j);
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, write ports, issue port and the busy vector.
interface regfile_mp_if
   import regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NRD   = 2,
   parameter int NWR   = 2
);
   localparam int AW = aw_of(NREGS);

   logic [NRD*AW-1:0]   i_raddr;
   logic [NRD*XLEN-1:0] o_rdata;
   logic [NRD-1:0]      o_rbusy;
   logic [NWR-1:0]      i_wen;
   logic [NWR*AW-1:0]   i_waddr;
   logic [NWR*XLEN-1:0] i_wdata;
   logic                i_iss_valid;
   logic [AW-1:0]       i_iss_rd;
   logic [NREGS-1:0]    o_busy_vec;

   modport slave (
      input  i_raddr, i_wen, i_waddr, i_wdata, i_iss_valid, i_iss_rd,
      output o_rdata, o_rbusy, o_busy_vec
   );

   modport master (
      output i_raddr, i_wen, i_waddr, i_wdata, i_iss_valid, i_iss_rd,
      input  o_rdata, o_rbusy, o_busy_vec
   );
endinterface

// File: rtl/regfile_rdport.sv
// One read port of regfile_mp: x0 mux, busy qualification and, when the
// RF_BYPASS_EN macro is defined, writeback-to-read forwarding.
module regfile_rdport
   import regfile_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int AW   = 5,
   parameter int NWR  = 2
) (
   input  logic [AW-1:0]       raddr_i,
   input  logic [XLEN-1:0]     stored_i,
   input  logic                busy_i,
   input  logic [NWR-1:0]      wen_i,
   input  logic [NWR*AW-1:0]   waddr_i,
   input  logic [NWR*XLEN-1:0] wdata_i,
   output logic [XLEN-1:0]     rdata_o,
   output logic                rbusy_o
);

`ifdef RF_BYPASS_EN
   always_comb begin
      wr_hit_t hits;
      wr_win_t win;
      hits = '0;
      for (int j = 0; j < NWR; j++) begin
         hits[j] = wen_i[j] && (waddr_i[j*AW +: AW] == raddr_i);
      end
      win     = win_port(hits);
      rdata_o = stored_i;
      rbusy_o = busy_i;
      if (raddr_i == '0) begin
         rdata_o = '0;
         rbusy_o = 1'b0;
      end else if (win.hit) begin
         // A same-cycle writeback satisfies the pending write, so decode may proceed.
         rdata_o = wdata_i[win.port*XLEN +: XLEN];
         rbusy_o = 1'b0;
      end
   end
`else
   logic unused_wr;
   assign unused_wr = ^{wen_i, waddr_i, wdata_i};

   always_comb begin
      rdata_o = stored_i;
      rbusy_o = busy_i;
      if (raddr_i == '0) begin
         rdata_o = '0;
         rbusy_o = 1'b0;
      end
   end
`endif

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with hardwired-zero x0 and a write-pending
// scoreboard. Forwarding is enabled by defining the RF_BYPASS_EN macro.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NRD   = 2,
   parameter int NWR   = 2
) (
   input  logic          i_clk,
   input  logic          i_rst,
   regfile_mp_if.slave   bus
);
   localparam int AW = aw_of(NREGS);

   logic [XLEN-1:0]          mem_q [1:NREGS-1];
   logic [XLEN-1:0]          mem_d [1:NREGS-1];
   logic [NREGS-1:1]         busy_q;
   logic [NREGS-1:1]         busy_d;
   logic [NREGS-1:0]         busy_vec;
   logic [NRD-1:0][XLEN-1:0] rdata_arr;
   logic [NRD-1:0]           rbusy_arr;

   // NOTE: every variable driven here gets a value on every path, so no latch is inferred.
   always_comb begin
      wr_hit_t hits;
      wr_win_t win;
      hits = '0;
      win  = '0;
      for (int r = 1; r < NREGS; r++) begin
         hits = '0;
         for (int j = 0; j < NWR; j++) begin
            hits[j] = bus.i_wen[j] && (bus.i_waddr[j*AW +: AW] == AW'(r));
         end
         win       = win_port(hits);
         mem_d[r]  = win.hit ? bus.i_wdata[win.port*XLEN +: XLEN] : mem_q[r];
         // Set after clear: a new issue supersedes the retiring writeback.
         busy_d[r] = (busy_q[r] && !win.hit) || (bus.i_iss_valid && (bus.i_iss_rd == AW'(r)));
      end
   end

   // NOTE: the storage array is reset on purpose: software expects every register to read 0 after reset.
   // NOTE: state is updated with non-blocking assignments so all registers sample the same pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int r = 1; r < NREGS; r++) mem_q[r] <= '0;
         busy_q <= '0;
      end else begin
         for (int r = 1; r < NREGS; r++) mem_q[r] <= mem_d[r];
         busy_q <= busy_d;
      end
   end

   assign busy_vec       = {busy_q, 1'b0};
   assign bus.o_busy_vec = busy_vec;
   assign bus.o_rdata    = rdata_arr;
   assign bus.o_rbusy    = rbusy_arr;

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   raddr;
      logic [XLEN-1:0] stored;

      assign raddr = bus.i_raddr[k*AW +: AW];

      always_comb begin
         stored = '0;
         for (int r = 1; r < NREGS; r++) begin
            if (raddr == AW'(r)) stored = mem_q[r];
         end
      end

      regfile_rdport #(
         .XLEN (XLEN),
         .AW   (AW),
         .NWR  (NWR)
      ) u_rdport (
         .raddr_i  (raddr),
         .stored_i (stored),
         .busy_i   (busy_vec[raddr]),
         .wen_i    (bus.i_wen),
         .waddr_i  (bus.i_waddr),
         .wdata_i  (bus.i_wdata),
         .rdata_o  (rdata_arr[k]),
         .rbusy_o  (rbusy_arr[k])
      );
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed table, hand-written corner
// sequences and randomized traffic against a behavioural array model.
module tb_regfile_mp;
   import regfile_pkg::*;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int NWR   = 2;
   localparam int AW    = aw_of(NREGS);

   logic i_clk = 1'b0;
   logic i_rst;
   always #5 i_clk = ~i_clk;

   regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [XLEN-1:0] mdl_regs [NREGS];
   logic            mdl_busy [NREGS];

   typedef struct {
      logic [1:0]  wen;
      int          wa0;
      logic [31:0] wd0;
      int          wa1;
      logic [31:0] wd1;
      logic        iss;
      int          iss_rd;
      int          ra0;
      int          ra1;
      logic [31:0] exp0;
      logic [31:0] exp1;
      logic        eb0;
      logic        eb1;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_idle();
      bus.i_wen       = '0;
      bus.i_waddr     = '0;
      bus.i_wdata     = '0;
      bus.i_iss_valid = 1'b0;
      bus.i_iss_rd    = '0;
      bus.i_raddr     = '0;
   endtask

   task automatic set_wr(input int j, input int addr, input logic [XLEN-1:0] data);
      bus.i_wen[j]                = 1'b1;
      bus.i_waddr[j*AW +: AW]     = AW'(addr);
      bus.i_wdata[j*XLEN +: XLEN] = data;
   endtask

   task automatic set_rd(input int k, input int addr);
      bus.i_raddr[k*AW +: AW] = AW'(addr);
   endtask

   task automatic set_iss(input int rd);
      bus.i_iss_valid = 1'b1;
      bus.i_iss_rd    = AW'(rd);
   endtask

   // Expected read value straight from the model, including forwarding when enabled.
   function automatic logic [XLEN-1:0] exp_rdata(input int addr);
      logic [XLEN-1:0] v;
      if (addr == 0) return '0;
      v = mdl_regs[addr];
`ifdef RF_BYPASS_EN
      for (int j = 0; j < NWR; j++)
         if (bus.i_wen[j] && int'(bus.i_waddr[j*AW +: AW]) == addr) v = bus.i_wdata[j*XLEN +: XLEN];
`endif
      return v;
   endfunction

   function automatic logic exp_rbusy(input int addr);
      logic b;
      if (addr == 0) return 1'b0;
      b = mdl_busy[addr];
`ifdef RF_BYPASS_EN
      for (int j = 0; j < NWR; j++)
         if (bus.i_wen[j] && int'(bus.i_waddr[j*AW +: AW]) == addr) b = 1'b0;
`endif
      return b;
   endfunction

   function automatic logic [NREGS-1:0] exp_busy_vec();
      logic [NREGS-1:0] v;
      for (int r = 0; r < NREGS; r++) v[r] = mdl_busy[r];
      return v;
   endfunction

   task automatic model_update();
      int   rd;
      int   a;
      logic wb;
      rd = int'(bus.i_iss_rd);
      if (i_rst) begin
         for (int r = 0; r < NREGS; r++) begin
            mdl_regs[r] = '0;
            mdl_busy[r] = 1'b0;
         end
         return;
      end
      wb = 1'b0;
      for (int j = 0; j < NWR; j++)
         if (bus.i_wen[j] && int'(bus.i_waddr[j*AW +: AW]) == rd) wb = 1'b1;
      assert (!(bus.i_iss_valid && rd != 0 && mdl_busy[rd] && !wb))
         else $error("WAW hazard: second writer issued to busy x%0d", rd);
      for (int j = 0; j < NWR; j++) begin
         a = int'(bus.i_waddr[j*AW +: AW]);
         if (bus.i_wen[j] && a != 0) begin
            mdl_regs[a] = bus.i_wdata[j*XLEN +: XLEN];
            mdl_busy[a] = 1'b0;
         end
      end
      if (bus.i_iss_valid && rd != 0) mdl_busy[rd] = 1'b1;
   endtask

   task automatic tick();
      @(posedge i_clk);
      model_update();
      @(negedge i_clk);
   endtask

   task automatic check_outputs(input string tag);
      int a;
      for (int k = 0; k < NRD; k++) begin
         a = int'(bus.i_raddr[k*AW +: AW]);
         check($sformatf("%s rdata%0d x%0d", tag, k, a), 64'(bus.o_rdata[k*XLEN +: XLEN]), 64'(exp_rdata(a)));
         check($sformatf("%s rbusy%0d x%0d", tag, k, a), 64'(bus.o_rbusy[k]), 64'(exp_rbusy(a)));
      end
      check($sformatf("%s busy_vec", tag), 64'(bus.o_busy_vec), 64'(exp_busy_vec()));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int wa [NWR];
      int rd;
      logic wb_hit;

      //                 wen    wa0 wd0           wa1 wd1           iss   rd  ra0 ra1 exp0          exp1          eb0   eb1
      vecs[0] = '{2'b11,  5, 32'hDEADBEEF,  0, 32'h00001234, 1'b0,  0,  5,  0, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
      vecs[1] = '{2'b11,  7, 32'h00000011,  7, 32'h00000022, 1'b0,  0,  7,  5, 32'h00000022, 32'hDEADBEEF, 1'b0, 1'b0};
      vecs[2] = '{2'b01,  7, 32'h00000033,  0, 32'h0,        1'b1, 12,  7, 12, 32'h00000033, 32'h0,        1'b0, 1'b1};
      vecs[3] = '{2'b10,  0, 32'h0,        12, 32'h00C0FFEE, 1'b0,  0, 12,  7, 32'h00C0FFEE, 32'h00000033, 1'b0, 1'b0};
      vecs[4] = '{2'b00,  0, 32'h0,         0, 32'h0,        1'b1,  0,  0, 12, 32'h0,        32'h00C0FFEE, 1'b0, 1'b0};
      vecs[5] = '{2'b11, 31, 32'hA5A5A5A5,  1, 32'h5A5A5A5A, 1'b0,  0, 31,  1, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1'b0};

      // Reset, then every address on every port reads zero and idle.
      set_idle();
      i_rst = 1'b1;
      @(negedge i_clk);
      tick();
      tick();
      i_rst = 1'b0;
      for (int a = 0; a < NREGS; a++) begin
         for (int k = 0; k < NRD; k++) set_rd(k, a);
         #1;
         for (int k = 0; k < NRD; k++) begin
            check($sformatf("reset rdata%0d x%0d", k, a), 64'(bus.o_rdata[k*XLEN +: XLEN]), 64'h0);
            check($sformatf("reset rbusy%0d x%0d", k, a), 64'(bus.o_rbusy[k]), 64'h0);
         end
         check("reset busy_vec", 64'(bus.o_busy_vec), 64'h0);
      end

      // Directed table: apply writes/issue for one edge, then read back idle.
      for (int i = 0; i < 6; i++) begin
         set_idle();
         if (vecs[i].wen[0]) set_wr(0, vecs[i].wa0, vecs[i].wd0);
         if (vecs[i].wen[1]) set_wr(1, vecs[i].wa1, vecs[i].wd1);
         if (vecs[i].iss) set_iss(vecs[i].iss_rd);
         tick();
         set_idle();
         set_rd(0, vecs[i].ra0);
         set_rd(1, vecs[i].ra1);
         #1;
         check($sformatf("vec%0d rdata0", i), 64'(bus.o_rdata[0 +: XLEN]), 64'(vecs[i].exp0));
         check($sformatf("vec%0d rdata1", i), 64'(bus.o_rdata[XLEN +: XLEN]), 64'(vecs[i].exp1));
         check($sformatf("vec%0d rbusy0", i), 64'(bus.o_rbusy[0]), 64'(vecs[i].eb0));
         check($sformatf("vec%0d rbusy1", i), 64'(bus.o_rbusy[1]), 64'(vecs[i].eb1));
         check_outputs($sformatf("vec%0d", i));
      end

      // Same-cycle conflict on x7 seen through a read port.
      set_idle();
      set_wr(0, 7, 32'h44);
      set_wr(1, 7, 32'h66);
      set_rd(0, 7);
      #1;
`ifdef RF_BYPASS_EN
      check("conflict bypass x7", 64'(bus.o_rdata[0 +: XLEN]), 64'h66);
`else
      check("conflict nobypass x7", 64'(bus.o_rdata[0 +: XLEN]), 64'h33);
`endif
      tick();
      set_idle();
      set_rd(0, 7);
      #1;
      check("conflict x7 after", 64'(bus.o_rdata[0 +: XLEN]), 64'h66);

      // Issue x3, wait two cycles, then write back 0x55.
      set_idle();
      set_iss(3);
      tick();
      set_idle();
      set_rd(0, 3);
      #1;
      check("x3 busy after issue", 64'(bus.o_rbusy[0]), 64'h1);
      check("x3 busy_vec after issue", 64'(bus.o_busy_vec[3]), 64'h1);
      tick();
      set_rd(0, 3);
      #1;
      check("x3 busy 2nd cycle", 64'(bus.o_rbusy[0]), 64'h1);
      tick();
      set_wr(0, 3, 32'h55);
      set_rd(0, 3);
      #1;
`ifdef RF_BYPASS_EN
      check("x3 wb-cycle rdata", 64'(bus.o_rdata[0 +: XLEN]), 64'h55);
      check("x3 wb-cycle rbusy", 64'(bus.o_rbusy[0]), 64'h0);
`else
      check("x3 wb-cycle rdata", 64'(bus.o_rdata[0 +: XLEN]), 64'h0);
      check("x3 wb-cycle rbusy", 64'(bus.o_rbusy[0]), 64'h1);
`endif
      check("x3 wb-cycle busy_vec", 64'(bus.o_busy_vec[3]), 64'h1);
      tick();
      set_idle();
      set_rd(0, 3);
      #1;
      check("x3 after wb rdata", 64'(bus.o_rdata[0 +: XLEN]), 64'h55);
      check("x3 after wb rbusy", 64'(bus.o_rbusy[0]), 64'h0);
      check("x3 after wb busy_vec", 64'(bus.o_busy_vec[3]), 64'h0);

      // Issue and writeback of x9 on the same edge: set wins.
      set_idle();
      set_iss(9);
      set_wr(1, 9, 32'h99);
      tick();
      set_idle();
      set_rd(1, 9);
      #1;
      check("x9 set-wins rdata", 64'(bus.o_rdata[XLEN +: XLEN]), 64'h99);
      check("x9 set-wins rbusy", 64'(bus.o_rbusy[1]), 64'h1);
      check("x9 set-wins busy_vec", 64'(bus.o_busy_vec[9]), 64'h1);
      set_wr(0, 9, 32'hAA);
      tick();
      set_idle();

      // Reset while x4 is busy and a write plus an issue to x4 sit on the reset edge.
      set_iss(4);
      tick();
      set_idle();
      set_rd(0, 4);
      #1;
      check("x4 busy before reset", 64'(bus.o_rbusy[0]), 64'h1);
      i_rst = 1'b1;
      set_wr(0, 4, 32'h77);
      set_iss(4);
      tick();
      i_rst = 1'b0;
      set_idle();
      set_rd(0, 4);
      set_rd(1, 5);
      #1;
      check("x4 after reset rdata", 64'(bus.o_rdata[0 +: XLEN]), 64'h0);
      check("x4 after reset rbusy", 64'(bus.o_rbusy[0]), 64'h0);
      check("x5 after reset rdata", 64'(bus.o_rdata[XLEN +: XLEN]), 64'h0);
      check("busy_vec after reset", 64'(bus.o_busy_vec), 64'h0);

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         set_idle();
         i_rst = ($urandom_range(0, 63) == 0);
         for (int j = 0; j < NWR; j++) begin
            wa[j] = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, NREGS - 1);
            bus.i_waddr[j*AW +: AW]     = AW'(wa[j]);
            bus.i_wdata[j*XLEN +: XLEN] = $urandom;
            bus.i_wen[j]                = ($urandom_range(0, 2) != 0);
         end
         if ($urandom_range(0, 1) == 0) begin
            rd = $urandom_range(0, 15);
            wb_hit = 1'b0;
            for (int j = 0; j < NWR; j++) if (bus.i_wen[j] && wa[j] == rd) wb_hit = 1'b1;
            if (!mdl_busy[rd] || wb_hit) set_iss(rd);
         end
         for (int k = 0; k < NRD; k++)
            set_rd(k, ($urandom_range(0, 2) == 0) ? wa[$urandom_range(0, NWR - 1)] : $urandom_range(0, NREGS - 1));
         #1;
         check_outputs($sformatf("rnd%0d", n));
         tick();
      end
      i_rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
